load_unit: RTL and testbench

Memory-read companion to the store-data path. Accepts a load request (address, access size, signedness), issues a word-aligned read to data memory, waits the fixed memory latency, then extracts the addressed byte, halfword, or word. It sign- or zero-extends that value and registers it as the load result, acting as the MDR, with a one-cycle `done` pulse. It sits between the control FSM and data memory on the LW/LH/LB/LHU/LBU path.

---
 rtl/load_unit_pkg.sv | 35 +++
 rtl/load_extract.sv | 45 ++++
 rtl/load_unit.sv | 124 ++++++++++++
 tb/tb_load_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared definitions for the load path: access-size codes, the load-unit
// state encoding, and the alignment rule used to reject bad requests.
package load_unit_pkg;

   // Access-size codes, shared with the store path and the control FSM.
   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   // Load-unit control states.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } lu_state_e;

   // A request is rejected when the size is reserved, or when a halfword or
   // word does not start on its natural boundary. Bytes are always aligned.
   function automatic logic is_misaligned(input logic [1:0] sz,
                                          input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (sz)
         SZ_WORD: bad = (offset != 2'b00);
         SZ_HALF: bad = offset[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_extract.sv
// Lane select and extension for loads: picks the addressed byte, halfword or
// word out of a little-endian memory word and sign- or zero-extends it.
// Purely combinational.
module load_extract
   import load_unit_pkg::*;
(
   input  logic [31:0] word_in,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] data_out
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Route the addressed byte and halfword lanes down to bit 0.
   always_comb begin
      // NOTE: every signal driven here gets a value before any branch, so no
      // path through the block can leave it unassigned and infer a latch.
      byte_sel = word_in[7:0];
      half_sel = word_in[15:0];
      case (offset)
         2'd0:    byte_sel = word_in[7:0];
         2'd1:    byte_sel = word_in[15:8];
         2'd2:    byte_sel = word_in[23:16];
         default: byte_sel = word_in[31:24];
      endcase
      // Halfword loads only reach here with offset 0 or 2.
      if (offset[1]) begin
         half_sel = word_in[31:16];
      end
   end

   // Widen the selected lane to 32 bits; word loads pass through untouched.
   always_comb begin
      data_out = word_in;
      case (size)
         SZ_HALF: data_out = {{16{sign_ext & half_sel[15]}}, half_sel};
         SZ_BYTE: data_out = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         default: data_out = word_in;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Load unit (MDR side of the data-memory path). Latches a load request,
// issues one word-aligned read, waits the fixed memory latency, then
// registers the extracted and extended result with a one-cycle done pulse.
// Misaligned or reserved-size requests finish immediately with err and never
// touch memory. Every output is a register or a decode of the state register.
module load_unit
   import load_unit_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] load_data
);

   // Wide enough to hold MEM_LAT itself.
   localparam int CNT_W = $clog2(MEM_LAT + 1);

   if (MEM_LAT < 1) begin : g_lat_check
      $error("load_unit: MEM_LAT must be at least 1");
   end

   lu_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [1:0]       size_q, size_d;
   logic             sext_q, sext_d;
   logic [31:0]      load_data_q, load_data_d;
   logic [31:0]      extract_data;

   // Lane select works from the latched request only, so the requester may
   // move on to the next address as soon as start has been accepted.
   load_extract u_extract (
      .word_in  (mem_rdata),
      .offset   (addr_q[1:0]),
      .size     (size_q),
      .sign_ext (sext_q),
      .data_out (extract_data)
   );

   // State, latency counter, latched request and MDR.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: state updates use non-blocking assignment so every register
         // samples the pre-edge values and ordering between blocks is moot.
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         size_q      <= SZ_WORD;
         sext_q      <= 1'b0;
         load_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         sext_q      <= sext_d;
         load_data_q <= load_data_d;
      end
   end

   // Next-state logic: accept in IDLE, one read strobe, count down, capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      size_d      = size_q;
      sext_d      = sext_q;
      load_data_d = load_data_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d = addr;
               size_d = size;
               sext_d = sign_ext;
               if (is_misaligned(size, addr[1:0])) begin
                  state_d = ERR;
               end else begin
                  state_d = REQ;
               end
            end
         end

         REQ: begin
            cnt_d   = CNT_W'(MEM_LAT);
            state_d = WAIT;
         end

         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Read data is valid in the last counted cycle.
            if (cnt_q == CNT_W'(1)) begin
               load_data_d = extract_data;
               state_d     = DONE;
            end
         end

         // Completion states last one cycle; start seen here is dropped.
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are pure decodes of registered state.
   assign mem_rd    = (state_q == REQ);
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE) || (state_q == ERR);
   assign err       = (state_q == ERR);
   assign load_data = load_data_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: two instances (MEM_LAT = 1 and 3) each with a small
// memory model and a scoreboard monitor. Stimulus pushes the expected
// completion of every request; the monitor compares cycle by cycle.
`timescale 1ns/1ps
module tb_load_unit;
   import load_unit_pkg::*;

   typedef struct {
      int          start_cyc;
      int          done_cyc;
      bit          err;
      logic [31:0] data;
      logic [31:0] waddr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  start;
   logic [31:0] addr;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] mem_data  [2];
   logic [31:0] mem_waddr [2];

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Reference rules, written as arithmetic on the address and data.
   function automatic bit ref_err(input logic [31:0] a, input logic [1:0] sz);
      return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
             (sz == 2'b00 && a % 4 != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] word,
                                            input logic [31:0] a,
                                            input logic [1:0] sz,
                                            input logic sx);
      longint v;
      int     off;
      off = int'(a % 4);
      if (sz == 2'b00) return word;
      if (sz == 2'b01) begin
         v = longint'((word >> (8 * off)) % 65536);
         if (sx && v >= 32768) v = v - 65536;
      end else begin
         v = longint'((word >> (8 * off)) % 256);
         if (sx && v >= 128) v = v - 256;
      end
      return 32'(v);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int LAT = (g == 0) ? 1 : 3;

      logic [31:0] mem_addr_w, mem_rdata_w, load_data_w;
      logic        mem_rd_w, busy_w, done_w, err_w;
      exp_t        q[$];

      load_unit #(.MEM_LAT(LAT)) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .start     (start[g]),
         .addr      (addr),
         .size      (size),
         .sign_ext  (sign_ext),
         .mem_addr  (mem_addr_w),
         .mem_rd    (mem_rd_w),
         .mem_rdata (mem_rdata_w),
         .busy      (busy_w),
         .done      (done_w),
         .err       (err_w),
         .load_data (load_data_w)
      );

      // Memory: data is valid only LAT cycles after the read strobe cycle,
      // and only for the word the stimulus placed at that address.
      initial begin
         int          ready_cyc;
         logic [31:0] rd_addr;
         ready_cyc   = -1;
         rd_addr     = '0;
         mem_rdata_w = '0;
         forever begin
            @(posedge clk);
            #1;
            if (mem_rd_w) begin
               ready_cyc = cyc + LAT;
               rd_addr   = mem_addr_w;
            end
            if (cyc == ready_cyc)
               mem_rdata_w = (rd_addr == mem_waddr[g]) ? mem_data[g] : 32'hBAD0_BAD0;
            else
               mem_rdata_w = $urandom;
         end
      end

      // Monitor: every cycle derive expected outputs from the queue front.
      initial begin
         exp_t        e;
         logic [31:0] cur_ld;
         bit          exp_busy, exp_rd, exp_done;
         cur_ld = '0;
         e      = '{start_cyc: 0, done_cyc: 0, err: 1'b0, data: '0, waddr: '0};
         forever begin
            @(negedge clk);
            if (!reset_n) begin
               q.delete();
               cur_ld = '0;
            end
            exp_busy = 1'b0;
            exp_rd   = 1'b0;
            exp_done = 1'b0;
            if (q.size() > 0) begin
               e        = q[0];
               exp_busy = (cyc > e.start_cyc) && (cyc <= e.done_cyc);
               exp_rd   = !e.err && (cyc == e.start_cyc + 1);
               exp_done = (cyc == e.done_cyc);
            end
            check($sformatf("lane%0d.busy", g), 32'(busy_w), 32'(exp_busy));
            check($sformatf("lane%0d.mem_rd", g), 32'(mem_rd_w), 32'(exp_rd));
            if (exp_rd)
               check($sformatf("lane%0d.mem_addr", g), mem_addr_w, e.waddr);
            check($sformatf("lane%0d.done", g), 32'(done_w), 32'(exp_done));
            check($sformatf("lane%0d.err", g), 32'(err_w), 32'(exp_done && e.err));
            if (exp_done) begin
               if (!e.err) cur_ld = e.data;
               void'(q.pop_front());
            end
            check($sformatf("lane%0d.load_data", g), load_data_w, cur_ld);
         end
      end
   end

   task automatic push_exp(input int g, input exp_t e);
      if (g == 0) g_lane[0].q.push_back(e);
      else        g_lane[1].q.push_back(e);
   endtask

   // Issue one request at the current cycle (called just after a rising
   // edge) and return in the first IDLE cycle after its completion. With
   // hold set, start stays high so the caller's next request is accepted
   // in that IDLE cycle.
   task automatic issue(input int g, input logic [31:0] a, input logic [1:0] sz,
                        input logic sx, input logic [31:0] data, input bit hold);
      exp_t e;
      int   c, n, k, lat;
      lat          = (g == 0) ? 1 : 3;
      c            = cyc;
      addr         = a;
      size         = sz;
      sign_ext     = sx;
      mem_data[g]  = data;
      mem_waddr[g] = {a[31:2], 2'b00};
      start[g]     = 1'b1;
      e.start_cyc  = c;
      e.err        = ref_err(a, sz);
      e.done_cyc   = e.err ? c + 1 : c + 2 + lat;
      e.data       = ref_load(data, a, sz, sx);
      e.waddr      = {a[31:2], 2'b00};
      push_exp(g, e);
      n = hold ? 0 : int'($urandom_range(e.done_cyc - c + 1, 1));
      k = 0;
      while (cyc < e.done_cyc + 1) begin
         @(posedge clk);
         #1;
         k++;
         if (!hold && k >= n) start[g] = 1'b0;
         addr     = $urandom;
         size     = 2'($urandom);
         sign_ext = 1'($urandom);
      end
   endtask

   initial begin
      exp_t e_abort;
      int   c0, gap;
      reset_n      = 1'b0;
      start        = '0;
      addr         = '0;
      size         = SZ_WORD;
      sign_ext     = 1'b0;
      mem_data     = '{32'h0, 32'h0};
      mem_waddr    = '{32'h0, 32'h0};

      repeat (3) @(posedge clk);
      #1;
      check("rst.mem_rd",    32'(g_lane[0].mem_rd_w),  32'h0);
      check("rst.mem_addr",  g_lane[0].mem_addr_w,     32'h0);
      check("rst.busy",      32'(g_lane[0].busy_w),    32'h0);
      check("rst.done",      32'(g_lane[0].done_w),    32'h0);
      check("rst.err",       32'(g_lane[0].err_w),     32'h0);
      check("rst.load_data", g_lane[0].load_data_w,    32'h0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed loads, MEM_LAT = 1.
      issue(0, 32'h100, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0);
      issue(0, 32'h102, SZ_BYTE, 1'b1, 32'h12F45678, 1'b0);
      issue(0, 32'h102, SZ_BYTE, 1'b0, 32'h12F45678, 1'b0);
      issue(0, 32'h202, SZ_HALF, 1'b1, 32'h80017FFF, 1'b0);
      issue(0, 32'h200, SZ_HALF, 1'b1, 32'h80017FFF, 1'b0);
      issue(0, 32'h101, SZ_HALF, 1'b0, 32'h55AA55AA, 1'b0);
      issue(0, 32'h102, SZ_WORD, 1'b0, 32'h55AA55AA, 1'b0);
      issue(0, 32'h100, SZ_RSVD, 1'b1, 32'h55AA55AA, 1'b0);

      // MEM_LAT = 3 with start held high across two back-to-back loads.
      issue(1, 32'h300, SZ_WORD, 1'b0, $urandom, 1'b1);
      issue(1, 32'h304, SZ_WORD, 1'b0, $urandom, 1'b0);

      // Randomized traffic on each lane.
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 40; i++) begin
            bit hold;
            hold = (i < 39) && ($urandom_range(3, 0) == 0);
            issue(g, $urandom, 2'($urandom), 1'($urandom), $urandom, hold);
            if (!hold) begin
               gap = int'($urandom_range(2, 0));
               repeat (gap) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
      end

      // Reset during WAIT on the MEM_LAT = 3 lane aborts the load.
      c0           = cyc;
      addr         = 32'h400;
      size         = SZ_WORD;
      sign_ext     = 1'b0;
      mem_data[1]  = $urandom;
      mem_waddr[1] = 32'h400;
      start[1]     = 1'b1;
      e_abort      = '{start_cyc: c0, done_cyc: c0 + 5, err: 1'b0,
                       data: 32'h0, waddr: 32'h400};
      push_exp(1, e_abort);
      @(posedge clk);
      #1;
      start[1] = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("abort.mem_rd",    32'(g_lane[1].mem_rd_w),  32'h0);
      check("abort.busy",      32'(g_lane[1].busy_w),    32'h0);
      check("abort.done",      32'(g_lane[1].done_w),    32'h0);
      check("abort.mem_addr",  g_lane[1].mem_addr_w,     32'h0);
      check("abort.load_data", g_lane[1].load_data_w,    32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // After reset: an error keeps the cleared MDR, then a normal load.
      issue(1, 32'h403, SZ_WORD, 1'b0, $urandom, 1'b0);
      issue(1, 32'h406, SZ_HALF, 1'b1, 32'h9ABC1234, 1'b0);
      issue(0, 32'h001, SZ_RSVD, 1'b0, $urandom, 1'b0);
      issue(0, 32'h003, SZ_BYTE, 1'b1, 32'h7F000000, 1'b0);

      start = '0;
      repeat (5) @(posedge clk);
      #1;
      check("lane0.queue_empty", 32'(g_lane[0].q.size()), 32'h0);
      check("lane1.queue_empty", 32'(g_lane[1].q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
